fir_coeff_reload_ctrl: RTL

//  Sequences a run-time coefficient reload for the transposed FIR filter. It accepts

---
 rtl/fir_coeff_reload_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fir_coeff_reload_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_coeff_reload_ctrl                                                      |
// | Serial coefficient reload sequencer: shadow-bank writes, drain, commit.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_coeff_reload_ctrl #(
   parameter  int DATA_WIDTH = 24,
   parameter  int FIR_DEPTH  = 48,
   localparam int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_cfg_start,
   input  logic                  i_cfg_din,
   input  logic                  i_cfg_din_valid,
   output logic                  o_cfg_ready,
   input  logic                  i_fir_idle,
   output logic                  o_fir_hold,
   output logic [ADDR_WIDTH-1:0] ov_coeff_addr,
   output logic [DATA_WIDTH-1:0] ov_coeff_data,
   output logic                  o_coeff_we,
   output logic                  o_coeff_commit,
   output logic                  o_busy
);

   localparam int BCNT_WIDTH = $clog2(DATA_WIDTH);
   localparam logic [BCNT_WIDTH-1:0] LAST_BIT  = BCNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FIR_DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_WRITE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   state_t                  state_q,    state_d;
   logic [BCNT_WIDTH-1:0]   bit_cnt_q,  bit_cnt_d;
   logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
   logic [DATA_WIDTH-1:0]   sreg_q,     sreg_d;
   logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
   logic [DATA_WIDTH-1:0]   data_q,     data_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         sreg_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         sreg_q     <= sreg_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      word_cnt_d     = word_cnt_q;
      sreg_d         = sreg_q;
      addr_d         = addr_q;
      data_d         = data_q;
      o_cfg_ready    = 1'b0;
      o_coeff_we     = 1'b0;
      o_coeff_commit = 1'b0;

      // With the enable low nothing advances and all strobes stay quiet.
      if (i_en) begin
         case (state_q)
            ST_IDLE: begin
               if (i_cfg_start) begin
                  state_d    = ST_SHIFT;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
               end
            end
            ST_SHIFT: begin
               o_cfg_ready = 1'b1;
               if (i_cfg_din_valid) begin
                  sreg_d = {sreg_q[DATA_WIDTH-2:0], i_cfg_din};
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_WRITE;
                     addr_d  = word_cnt_q;
                     data_d  = sreg_d;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               o_coeff_we = 1'b1;
               bit_cnt_d  = '0;
               if (word_cnt_q == LAST_WORD) begin
                  state_d = ST_DRAIN;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  state_d    = ST_SHIFT;
               end
            end
            ST_DRAIN: begin
               if (i_fir_idle) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
               o_coeff_commit = 1'b1;
               state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Write address/data are captured with the last bit so they hold between strobes.
   assign ov_coeff_addr = addr_q;
   assign ov_coeff_data = data_q;
   assign o_fir_hold    = (state_q == ST_DRAIN) || (state_q == ST_COMMIT);
   assign o_busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
